// File: rtl/load_store_unit_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
// slave: the LSU's view; master: the environment (core + memory).
interface load_store_unit_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, misaligned_o, bus_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, misaligned_o, bus_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: core requests to word memory accesses, load extension.
// Optional misaligned trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned MAX_WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    load_store_unit_if.slave  bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam int CW = (MAX_WAIT_CYCLES == 0) ? 1 : $clog2(MAX_WAIT_CYCLES + 1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]      r_off;
    logic [2:0]      r_size;

    logic            w_is_b, w_is_h, w_misal, w_timeout;
    logic            w_req, w_stall, w_err, w_mis_o;
    logic [3:0]      w_be;
    logic [31:0]     w_wd, w_load, w_rd, w_byte_sh;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    always_comb begin
        w_is_b = (bus.core_size_i == 3'd0) || (bus.core_size_i == 3'd4);
        w_is_h = (bus.core_size_i == 3'd1) || (bus.core_size_i == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        w_misal = (w_is_h && bus.core_addr_i[0]) ||
                  ((bus.core_size_i == 3'd2) && (bus.core_addr_i[1:0] != 2'd0));
`else
        w_misal = 1'b0;
`endif
        if (w_is_b) begin
            w_be = 4'b0001 << bus.core_addr_i[1:0];
            w_wd = {4{bus.core_wd_i[7:0]}};
        end else if (w_is_h) begin
            w_be = 4'b0011 << {bus.core_addr_i[1], 1'b0};
            w_wd = {2{bus.core_wd_i[15:0]}};
        end else begin
            w_be = 4'b1111;
            w_wd = bus.core_wd_i;
        end
    end

    // Load extraction uses the offset/size captured at issue time.
    always_comb begin
        w_byte_sh = bus.mem_rd_i >> {r_off, 3'b000};
        w_byte    = w_byte_sh[7:0];
        w_half    = r_off[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
        unique case (r_size)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_load = {24'd0, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = bus.mem_rd_i;
        endcase
    end

    assign w_timeout = (MAX_WAIT_CYCLES != 0) &&
                       (r_cnt == CW'(MAX_WAIT_CYCLES));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_err       = 1'b0;
        w_mis_o     = 1'b0;
        w_rd        = 32'd0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (bus.core_req_i) begin
                    if (w_misal) begin
                        w_mis_o = 1'b1;
                    end else begin
                        w_req       = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (bus.mem_ready_i) begin
                    w_rd        = bus.core_we_i ? 32'd0 : w_load;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_off   <= 2'd0;
            r_size  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == IDLE && bus.core_req_i && !w_misal) begin
                r_off  <= bus.core_addr_i[1:0];
                r_size <= bus.core_size_i;
            end
        end
    end

    assign bus.core_rd_o    = w_rd;
    assign bus.core_stall_o = w_stall;
    assign bus.misaligned_o = w_mis_o;
    assign bus.bus_err_o    = w_err;
    assign bus.mem_req_o    = w_req;
    assign bus.mem_we_o     = w_req & bus.core_we_i;
    assign bus.mem_be_o     = w_req ? w_be : 4'd0;
    assign bus.mem_addr_o   = w_req ? bus.core_addr_i : 32'd0;
    assign bus.mem_wd_o     = w_req ? w_wd : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level memory model.
// Build with +define+LSU_MISALIGN_TRAP_EN to cover the trap variant.
module tb_load_store_unit;

    localparam int MAXW = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] mem     [64];
    logic [31:0] last_rd;
    logic [3:0]  last_be;
    logic [31:0] last_wd;

    load_store_unit_if bus ();

    load_store_unit #(.MAX_WAIT_CYCLES(MAXW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory: registered read, byte-enabled write on every requested edge.
    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            if (bus.mem_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (bus.mem_be_o[i])
                        mem[bus.mem_addr_o[7:2]][8*i +: 8] <= bus.mem_wd_o[8*i +: 8];
            end else begin
                bus.mem_rd_i <= mem[bus.mem_addr_o[7:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int lane_base(input logic [2:0] sz, input logic [31:0] a);
        int o = int'(a % 4);
        return o - (o % nbytes(sz));
    endfunction

    function automatic bit is_mis(input logic [2:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (nbytes(sz) == 2 && (a % 2) != 0) || (sz == 3'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] a);
        logic [3:0] be = '0;
        int b = lane_base(sz, a);
        for (int i = 0; i < 4; i++)
            be[i] = (i >= b) && (i < b + nbytes(sz));
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] a);
        longint v = 0;
        int n = nbytes(sz);
        int b = lane_base(sz, a);
        for (int j = 0; j < n; j++)
            v += longint'(ref_mem[a[7:2]][8*(b+j) +: 8]) << (8*j);
        if ((sz == 3'd0 || sz == 3'd1) && v >= (longint'(1) << (8*n - 1)))
            v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int b = lane_base(sz, a);
        for (int j = 0; j < nbytes(sz); j++)
            ref_mem[a[7:2]][8*(b+j) +: 8] = wd[8*j +: 8];
    endtask

    // One access; d = number of not-ready WAIT cycles before mem_ready_i.
    task automatic access(input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input int d);
        logic [31:0] exp_rd;
        exp_rd = we ? 32'd0 : exp_load(sz, a);
        last_rd = 32'hDEAD_BEEF;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = we;
        bus.core_size_i = sz;
        bus.core_addr_i = a;
        bus.core_wd_i   = wd;
        bus.mem_ready_i = (d == 0);
        @(negedge clk);
        last_be = bus.mem_be_o;
        last_wd = bus.mem_wd_o;
        if (is_mis(sz, a)) begin
            chk("mis_flag", {31'd0, bus.misaligned_o}, 32'd1);
            chk("mis_req", {31'd0, bus.mem_req_o}, 32'd0);
            chk("mis_stall", {31'd0, bus.core_stall_o}, 32'd0);
            @(posedge clk); #1;
            bus.core_req_i = 1'b0;
            return;
        end
        chk("iss_stall", {31'd0, bus.core_stall_o}, 32'd1);
        chk("iss_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("iss_we", {31'd0, bus.mem_we_o}, {31'd0, we});
        chk("iss_addr", bus.mem_addr_o, a);
        chk("iss_be", {28'd0, bus.mem_be_o}, {28'd0, exp_be(sz, a)});
        if (we) chk("iss_wd", bus.mem_wd_o, exp_wd(sz, wd));
        chk("iss_rd", bus.core_rd_o, 32'd0);
        chk("iss_mis", {31'd0, bus.misaligned_o}, 32'd0);
        if (we) ref_store(sz, a, wd);
        @(posedge clk); #1;
        for (int k = 0; k <= MAXW; k++) begin
            bus.mem_ready_i = (k >= d);
            @(negedge clk);
            chk("wait_req", {31'd0, bus.mem_req_o}, 32'd1);
            if (k >= d) begin
                last_rd = bus.core_rd_o;
                chk("done_stall", {31'd0, bus.core_stall_o}, 32'd0);
                chk("done_err", {31'd0, bus.bus_err_o}, 32'd0);
                chk("done_rd", bus.core_rd_o, exp_rd);
            end else if (k == MAXW) begin
                chk("tmo_err", {31'd0, bus.bus_err_o}, 32'd1);
                chk("tmo_stall", {31'd0, bus.core_stall_o}, 32'd0);
                chk("tmo_rd", bus.core_rd_o, 32'd0);
            end else begin
                chk("wait_stall", {31'd0, bus.core_stall_o}, 32'd1);
                chk("wait_err", {31'd0, bus.bus_err_o}, 32'd0);
                chk("wait_rd", bus.core_rd_o, 32'd0);
            end
            @(posedge clk); #1;
            if (k >= d) break;
        end
        bus.core_req_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_stall", {31'd0, bus.core_stall_o}, 32'd0);
            chk("idle_req", {31'd0, bus.mem_req_o}, 32'd0);
            chk("idle_addr", bus.mem_addr_o, 32'd0);
            chk("idle_rd", bus.core_rd_o, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [2:0] sz;
        logic [2:0] szs [8];
        szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        rst = 1'b1;
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd0;
        bus.core_addr_i = 32'd0;
        bus.core_wd_i   = 32'd0;
        bus.mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, bus.core_stall_o}, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_rd", bus.core_rd_o, 32'd0);
        chk("rst_err", {31'd0, bus.bus_err_o}, 32'd0);
        chk("rst_mis", {31'd0, bus.misaligned_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 64; i++)
            access(1'b1, 3'd2, 32'h100 + 32'(4*i), $urandom, 0);

        access(1'b1, 3'd0, 32'h102, 32'h0000_00AB, 0);
        chk("plan_sb_be", {28'd0, last_be}, 32'h4);
        chk("plan_sb_wd", last_wd, 32'hABAB_ABAB);
        access(1'b1, 3'd2, 32'h100, 32'h80FF_1234, 0);
        access(1'b0, 3'd0, 32'h103, 32'd0, 0);
        chk("plan_lb", last_rd, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h103, 32'd0, 0);
        chk("plan_lbu", last_rd, 32'h0000_0080);
        access(1'b0, 3'd1, 32'h102, 32'd0, 0);
        chk("plan_lh", last_rd, 32'hFFFF_80FF);
        access(1'b0, 3'd5, 32'h102, 32'd0, 0);
        chk("plan_lhu", last_rd, 32'h0000_80FF);
        access(1'b0, 3'd2, 32'h100, 32'd0, 0);
        access(1'b1, 3'd2, 32'h104, 32'h1357_9BDF, 0);
        access(1'b0, 3'd2, 32'h104, 32'd0, 2);
        chk("plan_lw_slow", last_rd, 32'h1357_9BDF);
        access(1'b0, 3'd2, 32'h108, 32'd0, 6);
        access(1'b0, 3'd2, 32'h10C, 32'd0, MAXW);
        access(1'b0, 3'd2, 32'h101, 32'd0, 0);
        idle(1);

        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h110;
        bus.mem_ready_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_stall", {31'd0, bus.core_stall_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.core_req_i = 1'b0;
        @(negedge clk);
        chk("rstw_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rstw_stall0", {31'd0, bus.core_stall_o}, 32'd0);
        chk("rstw_rd", bus.core_rd_o, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 3'd2, 32'h110, 32'd0, 0);

        for (int i = 0; i < 300; i++) begin
            sz = szs[$urandom_range(0, 7)];
            access(1'($urandom_range(0, 1)), sz, 32'h100 + 32'($urandom_range(0, 255)),
                   $urandom, ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
